// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick shift chain: snapshots two button words on a low
// JOY_LOAD strobe and serialises them active-low on each JOY_CLK rising edge.
module joy_db15_tx #(
  parameter int BITS_PER_JOY = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 480000
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [BITS_PER_JOY-1:0]                 joystick1,
  input  logic [BITS_PER_JOY-1:0]                 joystick2,
  input  logic                                    joy_clk,
  input  logic                                    joy_load,
  output logic                                    joy_data,
  output logic                                    frame_done,
  output logic                                    link_active,
  output logic [$clog2(2*BITS_PER_JOY+1)-1:0]     bit_index
);

  localparam int W  = 2 * BITS_PER_JOY;
  localparam int IW = $clog2(W + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
  localparam logic [CW-1:0] TO_CNT   = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] ck_sync_q, ld_sync_q;
  logic                   ck_prev_q, ld_prev_q;
  logic [W-1:0]           sr_q;
  logic [IW-1:0]          idx_q;
  logic                   frame_done_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   link_q, link_d;

  logic         ck_s, ld_s, ck_rise, ld_low, ld_fall;
  logic [W-1:0] snap;

  assign ck_s    = ck_sync_q[SYNC_STAGES-1];
  assign ld_s    = ld_sync_q[SYNC_STAGES-1];
  assign ck_rise = ck_s & ~ck_prev_q;
  assign ld_low  = ~ld_s;
  assign ld_fall = ld_prev_q & ~ld_s;
  assign snap    = {~joystick2, ~joystick1};

  // Saturating link watchdog, rearmed by every synchronised load fall.
  always_comb begin
    cnt_d  = cnt_q;
    link_d = link_q;
    if (ld_fall) begin
      cnt_d  = '0;
      link_d = 1'b1;
    end else if (cnt_q != TO_CNT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == TO_CNT) link_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ck_sync_q    <= '0;
      ld_sync_q    <= '1;
      ck_prev_q    <= 1'b0;
      ld_prev_q    <= 1'b1;
      state_q      <= IDLE;
      sr_q         <= '1;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      link_q       <= 1'b0;
    end else begin
      ck_sync_q    <= {ck_sync_q[SYNC_STAGES-2:0], joy_clk};
      ld_sync_q    <= {ld_sync_q[SYNC_STAGES-2:0], joy_load};
      ck_prev_q    <= ck_s;
      ld_prev_q    <= ld_s;
      frame_done_q <= 1'b0;
      cnt_q        <= cnt_d;
      link_q       <= link_d;
      case (state_q)
        IDLE: if (ld_low) begin
          state_q <= LOAD;
          sr_q    <= snap;
          idx_q   <= '0;
        end
        LOAD: begin
          idx_q <= '0;
          if (ld_low) sr_q <= snap;
          else        state_q <= SHIFT;
        end
        SHIFT: begin
          // Load beats a coincident clock edge: the frame restarts.
          if (ld_low) begin
            state_q <= LOAD;
            sr_q    <= snap;
            idx_q   <= '0;
          end else if (ck_rise) begin
            sr_q <= {1'b1, sr_q[W-1:1]};
            if (idx_q == LAST_IDX) begin
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
              idx_q        <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign joy_data    = (state_q == IDLE) | sr_q[0];
  assign frame_done  = frame_done_q;
  assign link_active = link_q;
  assign bit_index   = idx_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: frames, snapshot, abort, load/clock race,
// pin-to-data latency, link watchdog and reset behaviour.
module tb_joy_db15_tx;
  localparam int B  = 12;
  localparam int W  = 24;
  localparam int TO = 200;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic [B-1:0] j1 = '0, j2 = '0;
  logic         joy_clk = 1'b0, joy_load = 1'b1;
  logic         joy_data, frame_done, link_active;
  logic [4:0]   bit_index;

  int n_cmp = 0, n_err = 0, fd_cnt = 0;

  joy_db15_tx #(.BITS_PER_JOY(B), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .joystick1(j1), .joystick2(j2),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_data(joy_data),
    .frame_done(frame_done), .link_active(link_active), .bit_index(bit_index)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic wait_n(input int n); repeat (n) @(negedge clk); endtask
  task automatic clk_pulse; joy_clk = 1'b1; wait_n(6); joy_clk = 1'b0; wait_n(6); endtask
  task automatic load_low;  joy_load = 1'b0; wait_n(6); endtask
  task automatic load_high; joy_load = 1'b1; wait_n(6); endtask

  // Shifts a whole frame, recording joy_data after each edge; optionally
  // changes joystick1 before edge chg_at.
  task automatic capture(input int chg_at, input logic [B-1:0] chg_val,
                         output logic [W-1:0] s);
    s[0] = joy_data;
    for (int k = 1; k <= W; k++) begin
      if (k == chg_at) j1 = chg_val;
      clk_pulse();
      if (k < W) s[k] = joy_data;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; wait_n(3); reset_n = 1'b1; wait_n(50);
    n_cmp++; if (joy_data !== 1'b1) begin n_err++; $display("FAIL reset_data got %b exp 1", joy_data); end
    n_cmp++; if (link_active !== 1'b0) begin n_err++; $display("FAIL reset_link got %b exp 0", link_active); end
    n_cmp++; if (bit_index !== 5'd0) begin n_err++; $display("FAIL reset_idx got %0d exp 0", bit_index); end
    n_cmp++; if (fd_cnt !== 0) begin n_err++; $display("FAIL reset_fd got %0d exp 0", fd_cnt); end
  endtask

  task automatic test_frame;
    logic [W-1:0] s;
    int fd0;
    fd0 = fd_cnt; j1 = 12'h001; j2 = 12'h800;
    load_low();
    n_cmp++; if (joy_data !== 1'b0) begin n_err++; $display("FAIL frame_bit0_at_load got %b exp 0", joy_data); end
    n_cmp++; if (bit_index !== 5'd0) begin n_err++; $display("FAIL frame_idx_at_load got %0d exp 0", bit_index); end
    load_high();
    capture(0, '0, s);
    n_cmp++; if (s !== 24'h7FFFFE) begin n_err++; $display("FAIL frame_stream got %h exp 7ffffe", s); end
    n_cmp++; if (bit_index !== 5'd0) begin n_err++; $display("FAIL frame_idx_end got %0d exp 0", bit_index); end
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_err++; $display("FAIL frame_done_count got %0d exp 1", fd_cnt - fd0); end
    for (int k = 0; k < 3; k++) begin
      clk_pulse();
      n_cmp++; if (joy_data !== 1'b1 || bit_index !== 5'd0) begin
        n_err++; $display("FAIL idle_extra_clk data %b idx %0d exp 1/0", joy_data, bit_index); end
    end
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_err++; $display("FAIL idle_extra_fd got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_snapshot;
    logic [W-1:0] s;
    j1 = 12'h000; j2 = 12'h000;
    load_low(); load_high();
    capture(4, 12'hFFF, s);
    n_cmp++; if (s !== 24'hFFFFFF) begin n_err++; $display("FAIL snapshot_hold got %h exp ffffff", s); end
    load_low(); load_high();
    capture(0, '0, s);
    n_cmp++; if (s !== 24'hFFF000) begin n_err++; $display("FAIL snapshot_next got %h exp fff000", s); end
  endtask

  task automatic test_abort;
    logic [W-1:0] s;
    int fd0;
    j1 = 12'h0F0; j2 = 12'h00F;
    load_low(); load_high();
    repeat (5) clk_pulse();
    n_cmp++; if (bit_index !== 5'd5) begin n_err++; $display("FAIL abort_idx_mid got %0d exp 5", bit_index); end
    fd0 = fd_cnt; j1 = 12'h003; j2 = 12'hC00;
    load_low();
    n_cmp++; if (bit_index !== 5'd0) begin n_err++; $display("FAIL abort_idx got %0d exp 0", bit_index); end
    n_cmp++; if (joy_data !== 1'b0) begin n_err++; $display("FAIL abort_bit0 got %b exp 0", joy_data); end
    n_cmp++; if (fd_cnt !== fd0) begin n_err++; $display("FAIL abort_no_fd got %0d exp %0d", fd_cnt, fd0); end
    load_high();
    capture(0, '0, s);
    n_cmp++; if (s !== 24'h3FFFFC) begin n_err++; $display("FAIL abort_new_frame got %h exp 3ffffc", s); end
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_err++; $display("FAIL abort_fd_after got %0d exp 1", fd_cnt - fd0); end
  endtask

  task automatic test_simul;
    logic [W-1:0] s;
    j1 = 12'h001; j2 = 12'h000;
    load_low(); load_high();
    repeat (2) clk_pulse();
    joy_clk = 1'b1; joy_load = 1'b0; wait_n(6);
    n_cmp++; if (bit_index !== 5'd0) begin n_err++; $display("FAIL race_idx got %0d exp 0", bit_index); end
    n_cmp++; if (joy_data !== 1'b0) begin n_err++; $display("FAIL race_data got %b exp 0", joy_data); end
    joy_clk = 1'b0; wait_n(6); joy_clk = 1'b1; wait_n(6);
    n_cmp++; if (bit_index !== 5'd0 || joy_data !== 1'b0) begin
      n_err++; $display("FAIL clk_in_load idx %0d data %b exp 0/0", bit_index, joy_data); end
    joy_clk = 1'b0; wait_n(6);
    load_high();
    capture(0, '0, s);
    n_cmp++; if (s !== 24'hFFFFFE) begin n_err++; $display("FAIL race_frame got %h exp fffffe", s); end
  endtask

  task automatic test_latency;
    j1 = 12'h002; j2 = 12'h000;
    load_low(); load_high();
    n_cmp++; if (joy_data !== 1'b1) begin n_err++; $display("FAIL lat_bit0 got %b exp 1", joy_data); end
    joy_clk = 1'b1; wait_n(2);
    n_cmp++; if (joy_data !== 1'b1 || bit_index !== 5'd0) begin
      n_err++; $display("FAIL lat_early data %b idx %0d exp 1/0", joy_data, bit_index); end
    wait_n(1);
    n_cmp++; if (joy_data !== 1'b0 || bit_index !== 5'd1) begin
      n_err++; $display("FAIL lat_exact data %b idx %0d exp 0/1", joy_data, bit_index); end
    joy_clk = 1'b0; wait_n(6);
  endtask

  task automatic test_timeout;
    wait_n(TO + 50);
    n_cmp++; if (link_active !== 1'b0) begin n_err++; $display("FAIL link_idle got %b exp 0", link_active); end
    load_low();
    n_cmp++; if (link_active !== 1'b1) begin n_err++; $display("FAIL link_up got %b exp 1", link_active); end
    load_high(); load_low(); load_high();
    wait_n(150);
    n_cmp++; if (link_active !== 1'b1) begin n_err++; $display("FAIL link_hold got %b exp 1", link_active); end
    wait_n(100);
    n_cmp++; if (link_active !== 1'b0) begin n_err++; $display("FAIL link_drop got %b exp 0", link_active); end
  endtask

  task automatic test_reset_mid;
    j1 = 12'h008; j2 = 12'h000;
    load_low(); load_high();
    repeat (3) clk_pulse();
    n_cmp++; if (joy_data !== 1'b0 || bit_index !== 5'd3) begin
      n_err++; $display("FAIL pre_reset data %b idx %0d exp 0/3", joy_data, bit_index); end
    reset_n = 1'b0; wait_n(1);
    n_cmp++; if (joy_data !== 1'b1) begin n_err++; $display("FAIL midreset_data got %b exp 1", joy_data); end
    n_cmp++; if (bit_index !== 5'd0 || link_active !== 1'b0) begin
      n_err++; $display("FAIL midreset_state idx %0d link %b exp 0/0", bit_index, link_active); end
    reset_n = 1'b1; wait_n(2);
    clk_pulse();
    n_cmp++; if (joy_data !== 1'b1 || bit_index !== 5'd0) begin
      n_err++; $display("FAIL post_reset_clk data %b idx %0d exp 1/0", joy_data, bit_index); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_abort();
    test_simul();
    test_latency();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side end of the serial DB15 joystick link: emulates the adapter's parallel-in/serial-out shift chain.
- Snapshots two 12-bit joystick words on JOY_LOAD and shifts them out on JOY_DATA, one bit per JOY_CLK rising edge.
- Sits in loopback/test builds and in the adapter-emulation top, driving USER_IN[5] from the host-side pins.
- Lets the host-side joy_db15 reader be exercised without external hardware.

Parameters:
- BITS_PER_JOY, 12, buttons per player word; frame length is 2*BITS_PER_JOY.
- SYNC_STAGES, 2, flip-flop stages on joy_clk and joy_load (minimum 2).
- TIMEOUT, 480000, clk cycles without a load pulse before link_active drops (10 ms at 48 MHz).

Ports:
- clk  in  1  system clock (48 MHz in the reference build).
- reset_n  in  1  synchronous reset, active-low.
- joystick1  in  BITS_PER_JOY  player 1 buttons, active-high pressed, sampled at load.
- joystick2  in  BITS_PER_JOY  player 2 buttons, active-high pressed, sampled at load.
- joy_clk  in  1  async shift clock from reader; rising edge advances.
- joy_load  in  1  async load strobe, active-low (74HC165 SH/LD style).
- joy_data  out  1  serial data, active-low (0 = pressed).
- frame_done  out  1  one-cycle pulse after the last bit of a frame is shifted past.
- link_active  out  1  high while load pulses arrive within TIMEOUT.
- bit_index  out  $clog2(2*BITS_PER_JOY+1)  current bit position, for debug and verification.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are named clk and reset_n.
- Synchronisation:
  - joy_clk and joy_load pass through SYNC_STAGES flip-flops each.
  - Edge detect uses one further register.
  - All events are evaluated on synchronised signals only.
- Reset (reset_n=0 at a clk edge):
  - joy_data=1, frame_done=0, link_active=0, bit_index=0.
  - State IDLE, shift register all ones, timeout counter 0.
  - Reset mid-frame abandons the frame immediately.
- Shift register:
  - 2*BITS_PER_JOY bits, loaded as {~joystick2, ~joystick1}.
  - The LSB is the output bit, so joystick1[0] goes first.
- States:
  - IDLE: joy_data=1. A synchronised joy_load low moves to LOAD.
  - LOAD: while load is low, reload the shift register every clk (continuous parallel load) and hold bit_index=0. joy_data is the register LSB, so the first bit is valid while load is low. On load rising, go to SHIFT.
  - SHIFT:
    - Each joy_clk rising edge shifts right and fills 1 at the MSB; bit_index increments.
    - When bit_index reaches 2*BITS_PER_JOY on that edge, pulse frame_done for one cycle and go to IDLE.
    - joy_load falling in SHIFT aborts the frame (no frame_done) and goes to LOAD.
- Latency:
  - joy_data changes exactly SYNC_STAGES+1 clk cycles after the joy_clk rising edge at the pin.
  - The load snapshot reflects joystick inputs from the same clk cycle as the internal load-low sample.
- Simultaneous joy_clk rise and joy_load low in the same cycle: load wins and the shift is ignored.
- joy_clk edges while load is low: ignored.
- Extra clocks after the frame (in IDLE): joy_data stays 1 (no button pressed); bit_index holds at 0.
- Timeout:
  - Counter resets on each synchronised load falling edge and saturates at TIMEOUT.
  - link_active=1 from the first load falling edge.
  - link_active=0 when the counter reaches TIMEOUT.
- Host constraint: joy_clk high and low phases must each be ≥ SYNC_STAGES+2 clk cycles. Shorter pulses are undefined and must not hang the FSM.

Test Plan:
- Reset released; no strobes applied -> joy_data=1, link_active=0, bit_index=0 indefinitely.
- joystick1=12'h001, joystick2=12'h800; load pulse, then 24 clocks -> serial stream is bit0=0 at load, bits1..22=1, bit23=0. frame_done pulses once, after the 24th edge. Final state IDLE.
- joystick1 changes from 12'h000 to 12'hFFF mid-shift -> the current frame still shows all 1s (the snapshot); the next frame shows the first 12 bits as 0.
- Load asserted again after 5 clocks -> bit_index returns to 0, no frame_done, and the full new frame shifts correctly.
- joy_clk rise in the same synchronised cycle as joy_load fall -> bit_index=0 and joy_data = ~joystick1[0].
- 2 load pulses, then TIMEOUT cycles silent -> link_active goes 1 then 0. reset_n=0 mid-frame -> joy_data=1 on the next clk.
